ray_gen: RTL and testbench
==========================

# ray_gen

Camera ray generator that sits directly upstream of `ray_tracer_top` and drives its ray input FIFO (`in_wr_en`, `ray_in`, `in_full`). On a start pulse it emits one primary ray per pixel of an `IMG_W` x `IMG_H` image in raster order (row 0 first, column 0 first), as six signed fixed-point words. Ray directions are produced incrementally by adders, with no multipliers. This replaces preloaded ray files, so the tracer can run frames from register-programmed camera vectors.

## Interface
- `D_BITS`, 32, word width; signed two's complement.
- `Q_BITS`, 10, fractional bits. Carried for consistency only; the block performs no scaling.
- `IMG_W`, 32, pixels per row; must be ≥ 1.
- `IMG_H`, 32, rows per frame; must be ≥ 1.
- `X_BITS`, `$clog2(IMG_W)` (minimum 1), width of `pixel_x`.
- `Y_BITS`, `$clog2(IMG_H)` (minimum 1), width of `pixel_y`.

Ports (name, direction, width, meaning):
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  frame start request; sampled only in IDLE.
- `cam_origin`  in  signed D_BITS x [2:0]  ray origin x, y, z; identical for every ray.
- `dir_base`  in  signed D_BITS x [2:0]  direction for pixel (0,0).
- `du`  in  signed D_BITS x [2:0]  direction step per column.
- `dv`  in  signed D_BITS x [2:0]  direction step per row.
- `in_full`  in  1  full flag of the downstream ray FIFO.
- `ray_wr_en`  out  1  write strobe; connects to tracer `in_wr_en`.
- `ray_out`  out  signed D_BITS x [5:0]  [0..2] origin x, y, z; [3..5] direction x, y, z.
- `pixel_x`  out  X_BITS  column of the ray currently on `ray_out`.
- `pixel_y`  out  Y_BITS  row of the ray currently on `ray_out`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last ray of a frame is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, with `start`=1:
  - latch `cam_origin`, `dir_base`, `du`, `dv` into internal registers;
  - set col=0, row=0, row_acc=dir_base, dir=dir_base;
  - next state RUN.
- IDLE, with `start`=0: remain in IDLE.
- RUN:
  - `ray_wr_en` = !`in_full`. This is combinational from the registered state, not a registered output.
  - `ray_out` = {latched origin, dir} at all times in RUN.
  - A ray is accepted in any RUN cycle where `ray_wr_en`=1.
- RUN, on accept:
  - if col < IMG_W-1: col+1, dir = dir + du.
  - else if row < IMG_H-1: col=0, row+1, row_acc = row_acc + dv, dir = row_acc + dv.
  - else (last pixel): next state DONE.
- RUN, no accept (`in_full`=1): all counters and accumulators hold. `ray_out`, `pixel_x` and `pixel_y` stay stable.
- DONE: `done`=1 for exactly one cycle, then unconditionally IDLE.
- `start` is ignored in RUN and DONE. It does not queue.
- Changes to the camera inputs after the start sample have no effect on the current frame.
- Arithmetic:
  - all adds are D_BITS signed, wrap modulo 2^D_BITS, no saturation, no rounding;
  - direction for pixel (x,y) = dir_base + x·du + y·dv, computed mod 2^D_BITS;
  - row_acc is updated by adding dv, so no error accumulates across rows.
- `reset` in any state:
  - next state IDLE;
  - `ray_wr_en`=0, `busy`=0, `done`=0;
  - counters and accumulators cleared to 0;
  - a frame in progress is abandoned and not resumed.

## Timing
- Reset values: `ray_wr_en`=0, `busy`=0, `done`=0, `pixel_x`=0, `pixel_y`=0, `ray_out` all 0.
- `start` high at edge t (in IDLE): `busy`=1 from cycle t+1. The first ray can be written in cycle t+1.
- Throughput: one ray per cycle while `in_full`=0.
- With no stalls, `ray_wr_en` is high for IMG_W·IMG_H consecutive cycles. `done` pulses in the cycle after the last write, with `busy`=0 in that same cycle.
- Stall response: `in_full` rising drops `ray_wr_en` in the same cycle, because the path is combinational. No ray is lost or duplicated.
- IMG_W=1: every accept takes the row-advance branch.
- IMG_W=IMG_H=1: exactly one write, then DONE.
- Earliest restart: the second cycle after `done`, since `start` is sampled in IDLE.

## Test plan
- Defaults, `in_full`=0; dir_base=(0xFFFFC000, 0xFFFFC000, 0x400), du=(0x200,0,0), dv=(0,0x200,0), origin=0:
  - exactly 1024 writes in 1024 consecutive cycles;
  - ray 0 direction x = 0xFFFFC000;
  - ray 31 direction x = 0xFFFFFE00 and y = 0xFFFFC000;
  - ray 32 direction y = 0xFFFFC200;
  - `done` pulses once, at cycle 1025 after `start`.
- Backpressure: `in_full` driven by a random ~50% pattern:
  - the written sequence equals the no-stall sequence;
  - count = 1024;
  - `ray_out`, `pixel_x` and `pixel_y` are held during every `in_full`=1 cycle.
- Reset mid-frame: assert `reset` after 100 writes.
  - Next cycle: `ray_wr_en`=0, `busy`=0, `done` never pulses.
  - A new `start` restarts at pixel (0,0) with dir=dir_base.
- Start handling:
  - `start` held high through RUN produces exactly one frame;
  - `start` pulsed in the DONE cycle is ignored;
  - inputs changed mid-frame do not alter the outputs.
- Wrap: du=(0x7FFFFFFF,0,0), dir_base=0 → ray 2 direction x = 0xFFFFFFFE, the mod 2^32 result.
- IMG_W=IMG_H=1: a single write with direction = dir_base, then `done`.

Source files
------------

// File: rtl/ray_gen.sv
// -----------------------------------------------------------------------------
// ray_gen
//
// Camera ray generator feeding the ray input FIFO of the tracer. A start
// request in IDLE captures the camera vectors. The block then emits one primary
// ray per pixel of an IMG_W x IMG_H image in raster order: row 0 first, and
// column 0 first within each row.
//
// Ray directions are formed incrementally, with adders only:
//   dir(x, y) = dir_base + x*du + y*dv   (mod 2^D_BITS)
// A row accumulator (row_acc) holds dir(0, y). The column walk restarts from
// the row accumulator on each new row, so column-step error never carries
// across rows.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   start       : frame start request, sampled only in IDLE
//   cam_origin  : ray origin x, y, z (same for every ray of a frame)
//   dir_base    : direction of pixel (0, 0)
//   du, dv      : direction step per column / per row
//   in_full     : downstream FIFO full flag
//   ray_wr_en   : write strobe into the FIFO (combinational: RUN && !in_full)
//   ray_out     : [0..2] origin x, y, z; [3..5] direction x, y, z
//   pixel_x/y   : pixel coordinates of the ray currently on ray_out
//   busy        : high while the frame is being emitted
//   done        : one-cycle pulse after the last ray of a frame is accepted
// -----------------------------------------------------------------------------
module ray_gen #(
    parameter int D_BITS = 32,
    parameter int Q_BITS = 10,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int X_BITS = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int Y_BITS = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [D_BITS-1:0] cam_origin [0:2],
    input  logic signed [D_BITS-1:0] dir_base   [0:2],
    input  logic signed [D_BITS-1:0] du         [0:2],
    input  logic signed [D_BITS-1:0] dv         [0:2],
    input  logic                     in_full,
    output logic                     ray_wr_en,
    output logic signed [D_BITS-1:0] ray_out    [0:5],
    output logic        [X_BITS-1:0] pixel_x,
    output logic        [Y_BITS-1:0] pixel_y,
    output logic                     busy,
    output logic                     done
);

    // Q_BITS only documents the fixed-point format; the datapath never rescales.
    if (IMG_W < 1 || IMG_H < 1 || Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_param_check
        $error("ray_gen: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [X_BITS-1:0] COL_LAST = X_BITS'(IMG_W - 1);
    localparam logic [Y_BITS-1:0] ROW_LAST = Y_BITS'(IMG_H - 1);

    state_t                     state_q,   state_d;
    logic        [X_BITS-1:0]   col_q,     col_d;
    logic        [Y_BITS-1:0]   row_q,     row_d;
    logic signed [D_BITS-1:0]   origin_q   [0:2];
    logic signed [D_BITS-1:0]   origin_d   [0:2];
    logic signed [D_BITS-1:0]   du_q       [0:2];
    logic signed [D_BITS-1:0]   du_d       [0:2];
    logic signed [D_BITS-1:0]   dv_q       [0:2];
    logic signed [D_BITS-1:0]   dv_d       [0:2];
    logic signed [D_BITS-1:0]   row_acc_q  [0:2];
    logic signed [D_BITS-1:0]   row_acc_d  [0:2];
    logic signed [D_BITS-1:0]   dir_q      [0:2];
    logic signed [D_BITS-1:0]   dir_d      [0:2];
    logic                       busy_q,    busy_d;
    logic                       done_q,    done_d;
    logic                       accept;

    // Next-state, pixel walk and direction accumulation.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        for (int i = 0; i < 3; i++) begin
            origin_d[i]  = origin_q[i];
            du_d[i]      = du_q[i];
            dv_d[i]      = dv_q[i];
            row_acc_d[i] = row_acc_q[i];
            dir_d[i]     = dir_q[i];
        end
        accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    col_d = {X_BITS{1'b0}};
                    row_d = {Y_BITS{1'b0}};
                    for (int i = 0; i < 3; i++) begin
                        origin_d[i]  = cam_origin[i];
                        du_d[i]      = du[i];
                        dv_d[i]      = dv[i];
                        row_acc_d[i] = dir_base[i];
                        dir_d[i]     = dir_base[i];
                    end
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // The write strobe is the accept condition; a full FIFO freezes everything.
                accept = ~in_full;
                if (accept) begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + X_BITS'(1);
                        for (int i = 0; i < 3; i++) begin
                            dir_d[i] = dir_q[i] + du_q[i];
                        end
                    end else if (row_q != ROW_LAST) begin
                        // New row: restart the column walk from the row accumulator.
                        col_d = {X_BITS{1'b0}};
                        row_d = row_q + Y_BITS'(1);
                        for (int i = 0; i < 3; i++) begin
                            row_acc_d[i] = row_acc_q[i] + dv_q[i];
                            dir_d[i]     = row_acc_q[i] + dv_q[i];
                        end
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= {X_BITS{1'b0}};
            row_q   <= {Y_BITS{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                origin_q[i]  <= {D_BITS{1'b0}};
                du_q[i]      <= {D_BITS{1'b0}};
                dv_q[i]      <= {D_BITS{1'b0}};
                row_acc_q[i] <= {D_BITS{1'b0}};
                dir_q[i]     <= {D_BITS{1'b0}};
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 3; i++) begin
                origin_q[i]  <= origin_d[i];
                du_q[i]      <= du_d[i];
                dv_q[i]      <= dv_d[i];
                row_acc_q[i] <= row_acc_d[i];
                dir_q[i]     <= dir_d[i];
            end
        end
    end

    // Output mapping: ray words come straight from the latched origin and current direction.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ray_out[i]     = origin_q[i];
            ray_out[3 + i] = dir_q[i];
        end
        ray_wr_en = accept;
        pixel_x   = col_q;
        pixel_y   = row_q;
        busy      = busy_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_ray_gen.sv
// -----------------------------------------------------------------------------
// tb_ray_gen
//
// Self-checking bench for ray_gen. The reference model computes each expected
// direction in closed form, base + x*du + y*dv (mod 2^32). It uses the camera
// values captured at the start sample and checks the rays in raster order.
// A second instance is built as a 1x1 image.
// -----------------------------------------------------------------------------
module tb_ray_gen;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset;
    logic               start;
    logic               in_full;
    logic signed [31:0] cam_origin [0:2];
    logic signed [31:0] dir_base   [0:2];
    logic signed [31:0] du         [0:2];
    logic signed [31:0] dv         [0:2];
    logic               ray_wr_en;
    logic signed [31:0] ray_out    [0:5];
    logic        [4:0]  pixel_x;
    logic        [4:0]  pixel_y;
    logic               busy;
    logic               done;

    logic               start1;
    logic               in_full1;
    logic               ray_wr_en1;
    logic signed [31:0] ray_out1   [0:5];
    logic        [0:0]  pixel_x1;
    logic        [0:0]  pixel_y1;
    logic               busy1;
    logic               done1;

    ray_gen #(.D_BITS(32), .Q_BITS(10), .IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cam_origin(cam_origin), .dir_base(dir_base), .du(du), .dv(dv),
        .in_full(in_full), .ray_wr_en(ray_wr_en), .ray_out(ray_out),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .busy(busy), .done(done)
    );

    ray_gen #(.D_BITS(32), .Q_BITS(10), .IMG_W(1), .IMG_H(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1),
        .cam_origin(cam_origin), .dir_base(dir_base), .du(du), .dv(dv),
        .in_full(in_full1), .ray_wr_en(ray_wr_en1), .ray_out(ray_out1),
        .pixel_x(pixel_x1), .pixel_y(pixel_y1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference camera captured at the start sample.
    logic [31:0] m_o  [0:2];
    logic [31:0] m_b  [0:2];
    logic [31:0] m_du [0:2];
    logic [31:0] m_dv [0:2];

    // Record of the last frame.
    logic [31:0] got_d [0:N-1][0:2];
    int          n_wr;
    int          first_wr;
    int          last_wr;
    int          done_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_dir(input int i, input int x, input int y);
        return m_b[i] + 32'(x) * m_du[i] + 32'(y) * m_dv[i];
    endfunction

    task automatic set_defaults();
        for (int i = 0; i < 3; i++) begin
            cam_origin[i] = 32'sd0;
            du[i]         = 32'sd0;
            dv[i]         = 32'sd0;
        end
        dir_base[0] = 32'shFFFFC000;
        dir_base[1] = 32'shFFFFC000;
        dir_base[2] = 32'sh00000400;
        du[0]       = 32'sh00000200;
        dv[1]       = 32'sh00000200;
    endtask

    task automatic randomize_cam();
        for (int i = 0; i < 3; i++) begin
            cam_origin[i] = $urandom;
            dir_base[i]   = $urandom;
            du[i]         = $urandom;
            dv[i]         = $urandom;
        end
    endtask

    // Runs one frame on the 32x32 instance, checking every cycle against the model.
    task automatic run_frame(input int stall_pct, input bit scramble,
                             input bit hold_start, input bit pulse_in_done);
        int          k;
        bit          fin;
        bit          prev_full;
        logic [31:0] prev [0:7];
        k        = 0;
        fin      = 1'b0;
        prev_full = 1'b0;
        first_wr = -1;
        last_wr  = -1;
        done_cyc = -1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            m_o[i]  = cam_origin[i];
            m_b[i]  = dir_base[i];
            m_du[i] = du[i];
            m_dv[i] = dv[i];
        end
        start   = 1'b1;
        in_full = 1'b0;
        for (int c = 1; c <= 4 * N + 50; c++) begin
            @(negedge clock);
            if (!hold_start) start = 1'b0;
            in_full = ($urandom_range(99) < stall_pct);
            if (scramble) randomize_cam();
            #1;
            if (done) begin
                fin      = 1'b1;
                done_cyc = c;
                chk("done_count", k, N);
                chk("done_busy", busy, 1'b0);
                chk("done_wr_en", ray_wr_en, 1'b0);
                break;
            end
            chk("busy", busy, 1'b1);
            chk("wr_en", ray_wr_en, !in_full);
            if (prev_full) begin
                for (int i = 0; i < 6; i++) chk($sformatf("hold_ray%0d", i), ray_out[i], prev[i]);
                chk("hold_px", 32'(pixel_x), prev[6]);
                chk("hold_py", 32'(pixel_y), prev[7]);
            end
            if (ray_wr_en) begin
                if (k < N) begin
                    chk($sformatf("px_k%0d", k), 32'(pixel_x), k % W);
                    chk($sformatf("py_k%0d", k), 32'(pixel_y), k / W);
                    for (int i = 0; i < 3; i++) begin
                        chk($sformatf("org%0d_k%0d", i, k), ray_out[i], m_o[i]);
                        chk($sformatf("dir%0d_k%0d", i, k), ray_out[3 + i], exp_dir(i, k % W, k / W));
                        got_d[k][i] = ray_out[3 + i];
                    end
                end else begin
                    chk("extra_write", 1'b1, 1'b0);
                end
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                k++;
            end
            for (int i = 0; i < 6; i++) prev[i] = ray_out[i];
            prev[6]   = 32'(pixel_x);
            prev[7]   = 32'(pixel_y);
            prev_full = in_full;
        end
        n_wr = k;
        if (!fin) chk("frame_timeout", 1'b0, 1'b1);
        start   = pulse_in_done;
        in_full = 1'b0;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("post_done_low", done, 1'b0);
        repeat (3) begin
            @(negedge clock);
            #1;
            chk("post_busy", busy, 1'b0);
            chk("post_wr_en", ray_wr_en, 1'b0);
        end
    endtask

    initial begin
        int k;
        logic [31:0] b1 [0:2];
        logic [31:0] o1 [0:2];

        reset    = 1'b1;
        start    = 1'b0;
        in_full  = 1'b0;
        start1   = 1'b0;
        in_full1 = 1'b0;
        set_defaults();

        // Reset state.
        repeat (3) @(negedge clock);
        #1;
        chk("rst_wr_en", ray_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_px", 32'(pixel_x), 32'd0);
        chk("rst_py", 32'(pixel_y), 32'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("rst_ray%0d", i), ray_out[i], 32'd0);
        reset = 1'b0;

        // Default camera, no stalls.
        run_frame(0, 1'b0, 1'b0, 1'b0);
        chk("nostall_writes", n_wr, N);
        chk("nostall_first", first_wr, 1);
        chk("nostall_last", last_wr, N);
        chk("nostall_done_cyc", done_cyc, N + 1);
        chk("ray0_dx", got_d[0][0], 32'hFFFFC000);
        chk("ray31_dx", got_d[31][0], 32'hFFFFFE00);
        chk("ray31_dy", got_d[31][1], 32'hFFFFC000);
        chk("ray32_dy", got_d[32][1], 32'hFFFFC200);

        // Default camera under ~50% backpressure.
        run_frame(50, 1'b0, 1'b0, 1'b0);
        chk("bp_writes", n_wr, N);

        // Reset after 100 writes.
        set_defaults();
        @(negedge clock);
        start = 1'b1;
        k = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (ray_wr_en) k++;
            if (k == 100) break;
        end
        chk("mid_reached_100", k, 100);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", ray_wr_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_px", 32'(pixel_x), 32'd0);
        repeat (5) begin
            @(negedge clock);
            #1;
            chk("mid_no_done", done, 1'b0);
            chk("mid_no_busy", busy, 1'b0);
        end
        run_frame(0, 1'b0, 1'b0, 1'b0);
        chk("restart_writes", n_wr, N);
        chk("restart_ray0_dx", got_d[0][0], 32'hFFFFC000);

        // Start held high through the whole frame.
        run_frame(30, 1'b0, 1'b1, 1'b0);
        chk("hold_start_writes", n_wr, N);

        // Random camera, inputs scrambled mid-frame, start pulsed in DONE.
        randomize_cam();
        run_frame(50, 1'b1, 1'b0, 1'b1);
        chk("rand_writes", n_wr, N);
        randomize_cam();
        run_frame(25, 1'b1, 1'b0, 1'b0);
        chk("rand2_writes", n_wr, N);

        // Wrap-around of the column adder.
        for (int i = 0; i < 3; i++) begin
            cam_origin[i] = 32'sd0;
            dir_base[i]   = 32'sd0;
            du[i]         = 32'sd0;
            dv[i]         = 32'sd0;
        end
        du[0] = 32'sh7FFFFFFF;
        run_frame(20, 1'b0, 1'b0, 1'b0);
        chk("wrap_ray2_dx", got_d[2][0], 32'hFFFFFFFE);
        chk("wrap_ray1_dx", got_d[1][0], 32'h7FFFFFFF);

        // 1x1 image on the second instance.
        randomize_cam();
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            b1[i] = dir_base[i];
            o1[i] = cam_origin[i];
        end
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        randomize_cam();
        #1;
        chk("one_wr_en", ray_wr_en1, 1'b1);
        chk("one_busy", busy1, 1'b1);
        chk("one_px", 32'(pixel_x1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("one_dir%0d", i), ray_out1[3 + i], b1[i]);
            chk($sformatf("one_org%0d", i), ray_out1[i], o1[i]);
        end
        @(negedge clock);
        #1;
        chk("one_done", done1, 1'b1);
        chk("one_done_wr_en", ray_wr_en1, 1'b0);
        chk("one_done_busy", busy1, 1'b0);
        @(negedge clock);
        #1;
        chk("one_done_low", done1, 1'b0);
        chk("one_idle_wr_en", ray_wr_en1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
